// File: rtl/eda_window_scan_ctrl_if.sv
// Pixel-stream, RAM-port and window-handshake bundle for eda_window_scan_ctrl.
// master = controller side, slave = pixel source / RAM / window consumer side.
interface eda_window_scan_ctrl_if #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 8
);
  logic                   pix_valid;
  logic [PIXEL_WIDTH-1:0] pix_data;
  logic                   pix_ready;
  logic                   ram_write_en;
  logic [ADDR_WIDTH-1:0]  ram_wr_addr;
  logic [PIXEL_WIDTH-1:0] ram_pixel_out;
  logic [ADDR_WIDTH-1:0]  ram_center_addr;
  logic [7:0]             neigh_valid;
  logic                   win_valid;
  logic                   win_ready;
  logic                   win_last;

  modport master (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, ram_write_en, ram_wr_addr, ram_pixel_out,
           ram_center_addr, neigh_valid, win_valid, win_last
  );

  modport slave (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, ram_write_en, ram_wr_addr, ram_pixel_out,
           ram_center_addr, neigh_valid, win_valid, win_last
  );
endinterface

// File: rtl/eda_window_scan_ctrl.sv
// Loads one raster frame into the 3x3 window RAM, then walks every centre address
// with border masks. Define SCAN_BORDER_SKIP_EN to visit interior centres only.
module eda_window_scan_ctrl #(
  parameter int unsigned M           = 16,
  parameter int unsigned N           = 16,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = $clog2(M*N)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  eda_window_scan_ctrl_if.master bus
);

  localparam int unsigned RW        = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW        = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned LAST_ADDR = M*N - 1;

`ifdef SCAN_BORDER_SKIP_EN
  localparam int R_FIRST = 1;
  localparam int C_FIRST = 1;
  localparam int R_LAST  = int'(N) - 2;
  localparam int C_LAST  = int'(M) - 2;
  localparam bit SCAN_OK = (M >= 3) && (N >= 3);
`else
  localparam int R_FIRST = 0;
  localparam int C_FIRST = 0;
  localparam int R_LAST  = int'(N) - 1;
  localparam int C_LAST  = int'(M) - 1;
  localparam bit SCAN_OK = 1'b1;
`endif
  // Address jump when the column wraps: skips any excluded border columns.
  localparam int WRAP_STEP  = int'(M) - C_LAST + C_FIRST;
  localparam int FIRST_ADDR = R_FIRST * int'(M) + C_FIRST;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_center, w_center_nxt;
  logic [RW-1:0]         r_row, w_row_nxt;
  logic [CW-1:0]         r_col, w_col_nxt;
  logic [7:0]            w_mask;
  logic                  w_last;
  logic                  w_col_wrap;

`ifdef SCAN_BORDER_SKIP_EN
  assign w_mask = 8'hFF;
`else
  logic w_up, w_dn, w_lf, w_rt;
  assign w_up   = (r_row != '0);
  assign w_dn   = (r_row != RW'(N - 1));
  assign w_lf   = (r_col != '0);
  assign w_rt   = (r_col != CW'(M - 1));
  assign w_mask = {w_up & w_lf, w_up, w_up & w_rt, w_lf, w_rt,
                   w_dn & w_lf, w_dn, w_dn & w_rt};
`endif

  assign w_col_wrap = (r_col == CW'(C_LAST));
  assign w_last     = (r_row == RW'(R_LAST)) && w_col_wrap;

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_wr_cnt <= '0;
      r_center <= '0;
      r_row    <= '0;
      r_col    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_center <= w_center_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    w_state_nxt         = r_state;
    w_wr_cnt_nxt        = r_wr_cnt;
    w_center_nxt        = r_center;
    w_row_nxt           = r_row;
    w_col_nxt           = r_col;
    bus.pix_ready       = 1'b0;
    bus.ram_write_en    = 1'b0;
    bus.ram_wr_addr     = '0;
    bus.ram_pixel_out   = '0;
    bus.ram_center_addr = '0;
    bus.neigh_valid     = '0;
    bus.win_valid       = 1'b0;
    bus.win_last        = 1'b0;
    busy                = 1'b0;
    done                = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_LOAD;
          w_wr_cnt_nxt = '0;
        end
      end
      S_LOAD: begin
        busy            = 1'b1;
        bus.pix_ready   = 1'b1;
        bus.ram_wr_addr = r_wr_cnt;
        if (bus.pix_valid) begin
          bus.ram_write_en  = 1'b1;
          bus.ram_pixel_out = PIXEL_WIDTH'(bus.pix_data);
          if (r_wr_cnt == ADDR_WIDTH'(LAST_ADDR)) begin
            w_state_nxt  = SCAN_OK ? S_SCAN : S_DONE;
            w_row_nxt    = RW'(R_FIRST);
            w_col_nxt    = CW'(C_FIRST);
            w_center_nxt = ADDR_WIDTH'(FIRST_ADDR);
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + ADDR_WIDTH'(1);
          end
        end
      end
      S_SCAN: begin
        busy                = 1'b1;
        bus.win_valid       = 1'b1;
        bus.ram_center_addr = r_center;
        bus.neigh_valid     = w_mask;
        bus.win_last        = w_last;
        if (bus.win_ready) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else if (w_col_wrap) begin
            w_col_nxt    = CW'(C_FIRST);
            w_row_nxt    = r_row + RW'(1);
            w_center_nxt = r_center + ADDR_WIDTH'(WRAP_STEP);
          end else begin
            w_col_nxt    = r_col + CW'(1);
            w_center_nxt = r_center + ADDR_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eda_window_scan_ctrl.sv
// Directed bench for eda_window_scan_ctrl at M=N=4: load, scan, backpressure,
// input gaps and mid-scan reset abort, with hand-computed expected values.
module tb_eda_window_scan_ctrl;
  localparam int unsigned M  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic busy;
  logic done;

  eda_window_scan_ctrl_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus_if ();

  eda_window_scan_ctrl #(.M(M), .N(N), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;

  always @(posedge clk) if (bus_if.ram_write_en) n_wr++;

  // Hand-computed masks for a 4x4 image, indexed by centre address
  logic [7:0] exp_mask [16] = '{8'h0B, 8'h1F, 8'h1F, 8'h16,
                                8'h6B, 8'hFF, 8'hFF, 8'hD6,
                                8'h6B, 8'hFF, 8'hFF, 8'hD6,
                                8'h68, 8'hF8, 8'hF8, 8'hD0};
`ifdef SCAN_BORDER_SKIP_EN
  int exp_addr [$] = '{5, 6, 9, 10};
`else
  int exp_addr [$] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus_if.pix_ready, bus_if.ram_write_en, bus_if.ram_wr_addr,
                bus_if.ram_pixel_out, bus_if.ram_center_addr, bus_if.neigh_valid,
                bus_if.win_valid, bus_if.win_last, busy, done});
  endfunction

  function automatic logic [7:0] mask_of(input int a);
`ifdef SCAN_BORDER_SKIP_EN
    return 8'hFF;
`else
    return exp_mask[a];
`endif
  endfunction

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feeds 16 pixels; with gap set, an idle cycle follows every non-final pixel
  task automatic load_frame(input bit gap);
    n_wr = 0;
    for (int i = 0; i < 16; i++) begin
      bus_if.pix_valid = 1'b1;
      bus_if.pix_data  = 8'(i * 7 + 3);
      @(negedge clk);
      chk("load_ready", 32'(bus_if.pix_ready), 32'd1);
      chk("load_we",    32'(bus_if.ram_write_en), 32'd1);
      chk("load_addr",  32'(bus_if.ram_wr_addr), 32'(i));
      chk("load_data",  32'(bus_if.ram_pixel_out), 32'(8'(i * 7 + 3)));
      @(posedge clk); #1;
      if (gap && i != 15) begin
        bus_if.pix_valid = 1'b0;
        @(negedge clk);
        chk("gap_we",   32'(bus_if.ram_write_en), 32'd0);
        chk("gap_addr", 32'(bus_if.ram_wr_addr), 32'(i + 1));
        @(posedge clk); #1;
      end
    end
    bus_if.pix_valid = 1'b0;
    chk("write_count", 32'(n_wr), 32'd16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    reset_n          = 1'b0;
    start            = 1'b0;
    bus_if.pix_valid = 1'b0;
    bus_if.pix_data  = '0;
    bus_if.win_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", all_outs(), 32'd0);
    @(posedge clk); #1;

    // Frame 1: continuous load, scan with a 3-cycle stall at address 6
    start_frame();
    load_frame(1'b0);
    bus_if.win_ready = 1'b1;
    for (int k = 0; k < exp_addr.size(); k++) begin
      a = exp_addr[k];
      if (a == 6) begin
        bus_if.win_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_addr", 32'(bus_if.ram_center_addr), 32'd6);
          chk("stall_mask", 32'(bus_if.neigh_valid), 32'hFF);
          @(posedge clk); #1;
        end
        bus_if.win_ready = 1'b1;
      end
      @(negedge clk);
      chk("scan_valid", 32'(bus_if.win_valid), 32'd1);
      chk("scan_addr",  32'(bus_if.ram_center_addr), 32'(a));
      chk("scan_mask",  32'(bus_if.neigh_valid), 32'(mask_of(a)));
      chk("scan_last",  32'(bus_if.win_last), 32'(k == exp_addr.size() - 1));
      chk("scan_done",  32'(done), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy",  32'(busy), 32'd0);
    chk("done_valid", 32'(bus_if.win_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Frame 2: gapped load, then reset abort at centre address 9
    start_frame();
    load_frame(1'b1);
    bus_if.win_ready = 1'b1;
    for (int k = 0; k < exp_addr.size(); k++) begin
      a = exp_addr[k];
      @(negedge clk);
      chk("scan2_addr", 32'(bus_if.ram_center_addr), 32'(a));
      if (a == 9) break;
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("abort_outs", all_outs(), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'({done, busy}), 32'd0);
      @(posedge clk); #1;
    end

    // Restart after abort must begin loading at address 0
    start_frame();
    @(negedge clk);
    chk("restart_ready", 32'(bus_if.pix_ready), 32'd1);
    chk("restart_addr",  32'(bus_if.ram_wr_addr), 32'd0);
    chk("restart_we",    32'(bus_if.ram_write_en), 32'd0);
    chk("restart_busy",  32'(busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
